instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Upstream neighbour of instruction_decoder. Holds the 12-bit program counter (PC) and the 16-bit instruction register (IR).
- Reads a synchronous instruction RAM with 1-cycle read latency and presents IR on `instruction`.
- Applies the decoder's `program_counter_jmp`, `jmp_addr` and `program_counter_no_inc` to select the next PC.
- Produces `exec_en`, the one-cycle commit strobe that gates every state write in the datapath. Also handles start/halt sequencing.

Parameters:
- PC_WIDTH, 12, PC, `iram_addr` and `jmp_addr` width.
- INSTR_WIDTH, 16, instruction and IR width.
- RESET_ADDR, 12'h000, PC value after reset and on every start.
- HALT_OPCODE, 4'hF, `instruction[15:12]` value that halts fetch.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution from RESET_ADDR; sampled only in IDLE or HALTED.
- iram_addr  out  PC_WIDTH  instruction RAM address, equal to the PC register.
- iram_rd_en  out  1  instruction RAM read enable.
- iram_data  in  INSTR_WIDTH  RAM read data, valid the cycle after `iram_rd_en`.
- instruction  out  INSTR_WIDTH  IR contents, fed to the decoder.
- program_counter_jmp  in  1  decoder jump request.
- jmp_addr  in  PC_WIDTH  decoder jump target.
- program_counter_no_inc  in  1  decoder stall request.
- exec_en  out  1  commit strobe for the current IR.
- pc  out  PC_WIDTH  current PC, for debug.
- busy  out  1  high in FETCH, LOAD and EXEC.
- done  out  1  high in HALTED.

Behaviour:
- Reset (asynchronous, any cycle, including mid-instruction):
  - state=IDLE, PC=RESET_ADDR, IR=16'h0000.
  - `iram_rd_en`, `exec_en`, `busy` and `done` all 0.
  - IR=0 decodes as a no-op in the decoder.
- State machine, one-hot or binary encoding free:
  - IDLE: if `start`, PC<=RESET_ADDR, go to FETCH.
  - FETCH: `iram_rd_en`=1, `iram_addr`=PC; go to LOAD.
  - LOAD: IR<=`iram_data`; go to EXEC.
  - EXEC, IR stable, decoder outputs valid. Priority order:
    1. `program_counter_no_inc`=1: stay in EXEC, `exec_en`=0, PC and IR unchanged.
    2. Else IR[15:12]==HALT_OPCODE: `exec_en`=1 for this cycle, go to HALTED, PC unchanged.
    3. Else `program_counter_jmp`=1: `exec_en`=1, PC<=`jmp_addr`, go to FETCH.
    4. Else: `exec_en`=1, PC<=PC+1 (modulo 2^PC_WIDTH, so 12'hFFF wraps to 12'h000), go to FETCH.
  - HALTED: `done`=1; IR held. If `start`, PC<=RESET_ADDR, `done` drops next cycle, go to FETCH.
- Steady state is 3 cycles per instruction (FETCH, LOAD, EXEC) plus any stall cycles. `exec_en` is high at most once per fetched instruction.
- `start` is ignored in FETCH, LOAD and EXEC.
- Outputs are registered or decoded from state only. There is no combinational path from `iram_data` to any output.
- `exec_en` is a function of state and `program_counter_no_inc`. This is the only combinational input-to-output path.
- `busy` = state in {FETCH, LOAD, EXEC}.
- A jump and a stall asserted in the same cycle: the stall wins. The jump is re-evaluated on the cycle the stall clears.
- `jmp_addr` equal to the current PC is legal (tight loop); the same address is re-fetched.
- Nothing is buffered across a stall; the decoder re-evaluates IR each stalled cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum `fetch_state_t` (IDLE, FETCH, LOAD, EXEC, HALTED);
  - PC_WIDTH and INSTR_WIDTH;
  - opcode constants, including OP_HALT=4'hF, alongside the decoder's opcodes 4'h1–4'hE.
- One natural sub-module, `program_counter`: PC register with async reset, load (`jmp_addr` or RESET_ADDR) and increment, plus a hold input. The FSM and IR stay in the top.

Test Plan:
- Reset, then `start` pulse; RAM[0]=16'h1000, RAM[1]=16'h2000 -> `iram_rd_en` in the FETCH cycle; `instruction`=16'h1000 in the first EXEC; `exec_en` pulses every 3 cycles; `pc` reads 0, 1, 2.
- RAM[2]=16'h9005 with the decoder forcing `program_counter_jmp`=1 and `jmp_addr`=12'h005 -> next `iram_addr`=12'h005; PC+1 (3) is never fetched.
- `program_counter_no_inc` high for 4 cycles in EXEC with `program_counter_jmp` also high -> `exec_en`=0 and PC/IR unchanged for 4 cycles; on release, `exec_en`=1 once and PC=`jmp_addr`.
- PC=12'hFFF, non-jump instruction -> the next fetch is from 12'h000.
- RAM[3]=16'hF000 -> `exec_en` pulses once, then `done`=1 and `busy`=0. A further `start` restarts from 12'h000 and clears `done`.
- `rst_n` asserted during LOAD -> asynchronous return to IDLE: IR=0, PC=0, `exec_en`=0, `done`=0; no fetch until `start`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, datapath widths and the opcode map
// used by both the fetch unit and the instruction decoder.
package cpu_pkg;

  localparam int PC_WIDTH    = 12;
  localparam int INSTR_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EXEC,
    HALTED
  } fetch_state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_JNZ   = 4'hB;
  localparam logic [3:0] OP_SHL   = 4'hC;
  localparam logic [3:0] OP_SHR   = 4'hD;
  localparam logic [3:0] OP_MOV   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[INSTR_WIDTH-1 -: 4];
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: hold has priority, then load, then increment.
// The increment wraps naturally at 2^PC_WIDTH.
module program_counter #(
  parameter int                    PC_WIDTH   = 12,
  parameter logic [PC_WIDTH-1:0]   RESET_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold_i,
  input  logic                load_i,
  input  logic [PC_WIDTH-1:0] load_addr_i,
  input  logic                inc_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (!hold_i) begin
      if (load_i) begin
        pc_d = load_addr_i;
      end else if (inc_i) begin
        pc_d = pc_q + PC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: sequences FETCH/LOAD/EXEC against a 1-cycle synchronous RAM,
// owns the IR and produces the exec_en commit strobe for the datapath.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                       PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int                       INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]      RESET_ADDR  = '0,
  parameter logic [3:0]               HALT_OPCODE = cpu_pkg::OP_HALT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    iram_addr,
  output logic                   iram_rd_en,
  input  logic [INSTR_WIDTH-1:0] iram_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   program_counter_jmp,
  input  logic [PC_WIDTH-1:0]    jmp_addr,
  input  logic                   program_counter_no_inc,
  output logic                   exec_en,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   busy,
  output logic                   done
);

  fetch_state_t            state_q, state_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  logic                    pc_hold, pc_load, pc_inc;
  logic [PC_WIDTH-1:0]     pc_load_addr;
  logic [PC_WIDTH-1:0]     pc_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // A stall outranks halt and jump; a jump held off by a stall is simply
  // re-evaluated from the decoder's live outputs once the stall drops.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    pc_hold      = 1'b0;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load_addr = RESET_ADDR;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        ir_d    = iram_data;
        state_d = EXEC;
      end
      EXEC: begin
        if (program_counter_no_inc) begin
          pc_hold = 1'b1;
        end else if (ir_q[INSTR_WIDTH-1 -: 4] == HALT_OPCODE) begin
          state_d = HALTED;
        end else if (program_counter_jmp) begin
          pc_load      = 1'b1;
          pc_load_addr = jmp_addr;
          state_d      = FETCH;
        end else begin
          pc_inc  = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iram_rd_en = (state_q == FETCH);
    exec_en    = (state_q == EXEC) && !program_counter_no_inc;
    busy       = (state_q == FETCH) || (state_q == LOAD) || (state_q == EXEC);
    done       = (state_q == HALTED);
  end

  program_counter #(
    .PC_WIDTH  (PC_WIDTH),
    .RESET_ADDR(RESET_ADDR)
  ) u_program_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_i     (pc_hold),
    .load_i     (pc_load),
    .load_addr_i(pc_load_addr),
    .inc_i      (pc_inc),
    .pc_o       (pc_value)
  );

  assign iram_addr   = pc_value;
  assign pc          = pc_value;
  assign instruction = ir_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: an ISA-level trace of the program in RAM predicts each
// committed (pc, instruction) pair and each fetch address.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [11:0] iram_addr;
  logic        iram_rd_en;
  logic [15:0] iram_data = '0;
  logic [15:0] instruction;
  logic        program_counter_jmp;
  logic [11:0] jmp_addr;
  logic        program_counter_no_inc;
  logic        exec_en;
  logic [11:0] pc;
  logic        busy;
  logic        done;

  logic        stallRand = 1'b0;
  logic        stallDir = 1'b0;
  bit          randStallEn = 1'b0;
  bit          gapCheckEn = 1'b0;
  int          runId = 0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [4096];
  logic [11:0] expPc[$];
  logic [15:0] expIr[$];
  logic [11:0] expFetch[$];

  instruction_fetch_unit dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .iram_addr             (iram_addr),
    .iram_rd_en            (iram_rd_en),
    .iram_data             (iram_data),
    .instruction           (instruction),
    .program_counter_jmp   (program_counter_jmp),
    .jmp_addr              (jmp_addr),
    .program_counter_no_inc(program_counter_no_inc),
    .exec_en               (exec_en),
    .pc                    (pc),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (iram_rd_en) iram_data <= mem[iram_addr];
  end

  // Minimal decoder: OP_JMP jumps to the low 12 bits of the instruction.
  assign program_counter_jmp    = (instruction[15:12] == OP_JMP);
  assign jmp_addr               = instruction[11:0];
  assign program_counter_no_inc = stallRand | stallDir;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s bound expired", name);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      stallRand = randStallEn ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  int negCount = 0;
  int lastExecNeg = 0;
  int lastExecRun = -1;

  always @(negedge clk) begin
    negCount++;
    if (rst_n) begin
      if (iram_rd_en && expFetch.size() > 0)
        checkOutput("fetchAddr", 32'(iram_addr), 32'(expFetch.pop_front()));
      if (exec_en) begin
        checkOutput("execWhileStalled", 32'(program_counter_no_inc), 32'd0);
        if (expPc.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extraExec actual pc=%0h instr=%0h required none", pc, instruction);
        end else begin
          checkOutput("execPc", 32'(pc), 32'(expPc.pop_front()));
          checkOutput("execIr", 32'(instruction), 32'(expIr.pop_front()));
        end
        if (gapCheckEn && lastExecRun == runId)
          checkOutput("execGap", 32'(negCount - lastExecNeg), 32'd3);
        lastExecNeg = negCount;
        lastExecRun = runId;
      end
    end
  end

  // Walk the program as an instruction-set simulator would.
  task automatic buildTrace(input int cap, output bit halted);
    logic [11:0] p;
    logic [15:0] instr;
    expPc.delete();
    expIr.delete();
    expFetch.delete();
    p = 12'h000;
    halted = 1'b0;
    for (int n = 0; n < cap; n++) begin
      instr = mem[p];
      expPc.push_back(p);
      expIr.push_back(instr);
      expFetch.push_back(p);
      if (instr[15:12] == 4'hF) begin
        halted = 1'b1;
        break;
      end
      if (instr[15:12] == 4'h9) p = instr[11:0];
      else p = p + 12'd1;
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    int i;
    i = 0;
    while (expPc.size() != 0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (expPc.size() != 0) failNow("drainTimeout");
  endtask

  task automatic waitFetchOf(input logic [11:0] addr);
    int i;
    i = 0;
    while (!(iram_rd_en && iram_addr == addr) && i < 60) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (!(iram_rd_en && iram_addr == addr)) failNow("waitFetch");
  endtask

  task automatic runProgram(input int cap, input bit stallOn, input bit gapOn);
    bit halted;
    buildTrace(cap, halted);
    runId++;
    randStallEn = stallOn;
    gapCheckEn = gapOn;
    applyStimulus();
    waitDrain(cap * 20 + 20);
    randStallEn = 1'b0;
    gapCheckEn = 1'b0;
    if (halted) begin
      @(posedge clk);
      #1;
      checkOutput("doneAfterHalt", 32'(done), 32'd1);
      checkOutput("busyAfterHalt", 32'(busy), 32'd0);
    end else begin
      resetDut();
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    bit halted;
    #500000;
    $display("[TB] FAIL watchdog bound expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit halted;
    clearMem();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstRdEn", 32'(iram_rd_en), 32'd0);
    checkOutput("rstExecEn", 32'(exec_en), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstPc", 32'(pc), 32'd0);
    checkOutput("rstIr", 32'(instruction), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Straight-line, jump over pc 3, jump to 0xFFF and wrap to 0.
    mem[12'h000] = 16'h1000;
    mem[12'h001] = 16'h2000;
    mem[12'h002] = 16'h9005;
    mem[12'h005] = 16'h9FFF;
    mem[12'hFFF] = 16'h4000;
    runProgram(7, 1'b0, 1'b1);

    // Stall over a pending jump, then halt and restart.
    clearMem();
    mem[12'h000] = 16'h1000;
    mem[12'h001] = 16'h2000;
    mem[12'h002] = 16'h9005;
    mem[12'h005] = 16'h7000;
    mem[12'h006] = 16'h9003;
    mem[12'h003] = 16'hF000;
    buildTrace(20, halted);
    runId++;
    applyStimulus();
    waitFetchOf(12'h002);
    stallDir = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stallExecEn", 32'(exec_en), 32'd0);
      checkOutput("stallPc", 32'(pc), 32'h002);
      checkOutput("stallIr", 32'(instruction), 32'h9005);
    end
    @(posedge clk);
    #1 stallDir = 1'b0;
    waitDrain(60);
    @(posedge clk);
    #1;
    checkOutput("haltDone", 32'(done), 32'd1);
    checkOutput("haltBusy", 32'(busy), 32'd0);
    checkOutput("haltPcHeld", 32'(pc), 32'h003);
    checkOutput("haltIrHeld", 32'(instruction), 32'hF000);
    buildTrace(20, halted);
    runId++;
    applyStimulus();
    checkOutput("restartDone", 32'(done), 32'd0);
    checkOutput("restartBusy", 32'(busy), 32'd1);
    checkOutput("restartRdEn", 32'(iram_rd_en), 32'd1);
    checkOutput("restartAddr", 32'(iram_addr), 32'h000);
    waitDrain(60);
    @(posedge clk);
    #1;
    checkOutput("rehaltDone", 32'(done), 32'd1);

    // Asynchronous reset while the second instruction is in LOAD.
    resetDut();
    clearMem();
    mem[12'h000] = 16'h1000;
    mem[12'h001] = 16'h2000;
    buildTrace(1, halted);
    expFetch.push_back(12'h001);
    runId++;
    applyStimulus();
    waitFetchOf(12'h001);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstIr", 32'(instruction), 32'd0);
    checkOutput("midRstPc", 32'(pc), 32'd0);
    checkOutput("midRstExecEn", 32'(exec_en), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstCommitted", 32'(expPc.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("noFetchWithoutStart", 32'(iram_rd_en), 32'd0);
    end

    // Random programs with random stalls.
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
      runProgram(25, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
